// File: rtl/vip_frame_ctrl_if.sv
// vip_frame_ctrl_if: control, video-sync and status bundle for vip_frame_ctrl; carries err_cnt when VIP_FRAME_CTRL_ERRCNT_EN is defined
interface vip_frame_ctrl_if;
  logic cfg_en, cfg_bypass, in_vsync, in_href;
  logic pipe_en, pipe_bypass, frame_start, frame_done, err_width, err_height, busy;
  logic [15:0] frame_cnt;
`ifdef VIP_FRAME_CTRL_ERRCNT_EN
  logic [15:0] err_cnt;
`endif
  modport master (
    output cfg_en, cfg_bypass, in_vsync, in_href,
    input  pipe_en, pipe_bypass, frame_start, frame_done, err_width, err_height, busy, frame_cnt
`ifdef VIP_FRAME_CTRL_ERRCNT_EN
    , err_cnt
`endif
  );
  modport slave (
    input  cfg_en, cfg_bypass, in_vsync, in_href,
    output pipe_en, pipe_bypass, frame_start, frame_done, err_width, err_height, busy, frame_cnt
`ifdef VIP_FRAME_CTRL_ERRCNT_EN
    , err_cnt
`endif
  );
endinterface

// File: rtl/vip_frame_ctrl.sv
// vip_frame_ctrl: frame-locked enable/bypass controller with line and frame size checking; optional err_cnt via VIP_FRAME_CTRL_ERRCNT_EN
module vip_frame_ctrl #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int LAT    = 3
) (
  input logic pclk,
  input logic rst,
  vip_frame_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} state_t;
  state_t state, state_nx;
  logic vsync_q, href_q, shadow;
  logic [15:0] pix_cnt, line_cnt;
  logic [LAT-1:0] done_sr;
  logic vs_rise, start, line_end, last_line;
  assign vs_rise   = io.in_vsync & ~vsync_q;
  assign start     = vs_rise & (((state == WAIT) & io.cfg_en) | (state == ACTIVE));
  // a vsync rise takes precedence over a coincident href fall
  assign line_end  = (state == ACTIVE) & ~io.in_href & href_q & ~vs_rise;
  assign last_line = line_end & ((line_cnt + 16'd1) == 16'(HEIGHT));
  assign io.pipe_en     = (state == ACTIVE) | (state == DONE);
  assign io.pipe_bypass = io.pipe_en & shadow;
  assign io.busy        = state == ACTIVE;
  assign io.frame_done  = done_sr[LAT-1];
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)   ? (io.cfg_en ? WAIT : IDLE) :
               (state == WAIT)   ? (!io.cfg_en ? IDLE : vs_rise ? ACTIVE : WAIT) :
               (state == ACTIVE) ? (vs_rise ? ACTIVE : last_line ? DONE : ACTIVE) :
                                   (io.cfg_en ? WAIT : IDLE);
  end
  always_ff @(posedge pclk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q        <= 1'b0;
      href_q         <= 1'b0;
      shadow         <= 1'b0;
      pix_cnt        <= '0;
      line_cnt       <= '0;
      done_sr        <= '0;
      io.frame_start <= 1'b0;
      io.err_width   <= 1'b0;
      io.err_height  <= 1'b0;
      io.frame_cnt   <= '0;
    end else begin
      vsync_q        <= io.in_vsync;
      href_q         <= io.in_href;
      io.frame_start <= start;
      io.err_height  <= start & (state == ACTIVE);
      io.err_width   <= line_end & (pix_cnt != 16'(WIDTH));
      done_sr        <= LAT'({done_sr, state == DONE});
      if (state == DONE) io.frame_cnt <= io.frame_cnt + 16'd1;
      if (start) begin
        shadow   <= io.cfg_bypass;
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (line_end) begin
        pix_cnt  <= '0;
        line_cnt <= line_cnt + 16'd1;
      end else if ((state == ACTIVE) & io.in_href & (pix_cnt != 16'hffff)) begin
        pix_cnt  <= pix_cnt + 16'd1;
      end
    end
  end
`ifdef VIP_FRAME_CTRL_ERRCNT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, io.err_cnt} + 17'(io.err_width) + 17'(io.err_height);
  always_ff @(posedge pclk)
    io.err_cnt <= rst ? '0 : err_sum[16] ? 16'hffff : err_sum[15:0];
`endif
endmodule
